alu_writeback_stage: RTL and testbench



---
 rtl/alu_writeback_stage.sv | 165 ++++++++++++++++
 tb/tb_alu_writeback_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage: buffers ALU results in a 2-entry in-order queue,
// truncates each result to its destination size, commits to the register file
// and the architectural flags, and forwards the youngest pending carry to the ALU.
module alu_writeback_stage #(
   parameter int DATA_WIDTH     = 64,
   parameter int REG_ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_result,
   input  logic                      in_z,
   input  logic                      in_n,
   input  logic                      in_c,
   input  logic                      in_sn,
   input  logic [1:0]                in_size,
   input  logic [REG_ADDR_WIDTH-1:0] in_dest,
   input  logic                      in_write,
   input  logic                      in_setflags,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_addr,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
   input  logic                      rf_ready,
   output logic [3:0]                flags_q,
   output logic                      carry_fwd
);

   // One buffered result; flags are packed {z,n,c,sn} so bit 1 is the carry.
   typedef struct packed {
      logic [DATA_WIDTH-1:0]     data;
      logic [3:0]                flags;
      logic [REG_ADDR_WIDTH-1:0] dest;
      logic                      write;
      logic                      setflags;
   } entry_t;

   entry_t                    head_q, head_d;
   entry_t                    tail_q, tail_d;
   entry_t                    in_entry;
   logic [1:0]                count_q, count_d;
   logic [3:0]                flags_d;
   logic [REG_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
   logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
   logic                      head_valid;
   logic                      push;
   logic                      pop;

   // Zero-extend the result from its destination operand size.
   function automatic logic [DATA_WIDTH-1:0] mask_result(
      input logic [DATA_WIDTH-1:0] r,
      input logic [1:0]            sz
   );
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      case (sz)
         2'd0:    m[7:0]  = r[7:0];
         2'd1:    m[15:0] = r[15:0];
         2'd2:    m[31:0] = r[31:0];
         default: m       = r;
      endcase
      return m;
   endfunction

   // Handshake and commit decisions; in_ready looks only at registered occupancy.
   always_comb begin
      head_valid = (count_q != 2'd0);
      in_ready   = (count_q < 2'd2);
      push       = in_valid && in_ready && !flush;
      pop        = head_valid && (!head_q.write || rf_ready);

      in_entry.data     = mask_result(in_result, in_size);
      in_entry.flags    = {in_z, in_n, in_c, in_sn};
      in_entry.dest     = in_dest;
      in_entry.write    = in_write;
      in_entry.setflags = in_setflags;
   end

   // Next-state for the queue, the flags register and the held output values.
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      flags_d     = flags_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;

      if (pop && head_q.setflags) begin
         flags_d = head_q.flags;
      end

      if (head_valid) begin
         hold_addr_d = head_q.dest;
         hold_data_d = head_q.data;
      end

      if (flush) begin
         count_d = 2'd0;
      end else begin
         case (count_q)
            2'd0: begin
               if (push) begin
                  head_d  = in_entry;
                  count_d = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_d = in_entry;
               end else if (pop) begin
                  count_d = 2'd0;
               end else if (push) begin
                  tail_d  = in_entry;
                  count_d = 2'd2;
               end
            end
            default: begin
               if (pop) begin
                  head_d  = tail_q;
                  count_d = 2'd1;
               end
            end
         endcase
      end
   end

   // State registers with synchronous reset taking priority over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= 2'd0;
         flags_q     <= 4'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         flags_q     <= flags_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
      end
   end

   // Register-file port shows the head; when empty it keeps the last head seen.
   always_comb begin
      rf_we    = head_valid && head_q.write;
      rf_addr  = head_valid ? head_q.dest : hold_addr_q;
      rf_wdata = head_valid ? head_q.data : hold_data_q;
   end

   // Youngest pending flag-setting entry wins the carry, else the architectural carry.
   always_comb begin
      if ((count_q == 2'd2) && tail_q.setflags) begin
         carry_fwd = tail_q.flags[1];
      end else if (head_valid && head_q.setflags) begin
         carry_fwd = head_q.flags[1];
      end else begin
         carry_fwd = flags_q[1];
      end
   end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: a vector table for single-entry flow
// plus hand-written sequences for stalls, carry forwarding, flush and reset.
module tb_alu_writeback_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_result;
   logic        in_z, in_n, in_c, in_sn;
   logic [1:0]  in_size;
   logic [7:0]  in_dest;
   logic        in_write;
   logic        in_setflags;
   logic        rf_we;
   logic [7:0]  rf_addr;
   logic [63:0] rf_wdata;
   logic        rf_ready;
   logic [3:0]  flags_q;
   logic        carry_fwd;

   int n_compared;
   int n_mismatched;

   logic [63:0] wr_log [64];
   int          wr_count;

   typedef struct {
      logic        vld;
      logic [63:0] res;
      logic [1:0]  size;
      logic [7:0]  dest;
      logic        wr;
      logic        sf;
      logic [3:0]  fl;
      logic        rdy;
      logic        e_we;
      logic [7:0]  e_addr;
      logic [63:0] e_data;
      logic [3:0]  e_flags;
      logic        e_ready;
      logic        e_carry;
   } vec_t;

   vec_t vecs [9];

   alu_writeback_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_z        (in_z),
      .in_n        (in_n),
      .in_c        (in_c),
      .in_sn       (in_sn),
      .in_size     (in_size),
      .in_dest     (in_dest),
      .in_write    (in_write),
      .in_setflags (in_setflags),
      .rf_we       (rf_we),
      .rf_addr     (rf_addr),
      .rf_wdata    (rf_wdata),
      .rf_ready    (rf_ready),
      .flags_q     (flags_q),
      .carry_fwd   (carry_fwd)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every accepted register-file write, sampled mid-cycle.
   initial wr_count = 0;
   always @(negedge clk) begin
      if (rf_we === 1'b1 && rf_ready === 1'b1 && rst === 1'b0) begin
         if (wr_count < 64) wr_log[wr_count] = rf_wdata;
         wr_count = wr_count + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic vld, input logic [63:0] res, input logic [1:0] size,
                                input logic [7:0] dest, input logic wr, input logic sf,
                                input logic [3:0] fl);
      in_valid    = vld;
      in_result   = res;
      in_size     = size;
      in_dest     = dest;
      in_write    = wr;
      in_setflags = sf;
      {in_z, in_n, in_c, in_sn} = fl;
   endtask

   task automatic idleIn();
      applyStimulus(1'b0, 64'h0, 2'd0, 8'd0, 1'b0, 1'b0, 4'b0);
   endtask

   initial begin
      int wc;
      n_compared   = 0;
      n_mismatched = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      rf_ready = 1'b1;
      idleIn();

      vecs[0] = '{1'b1, 64'h3, 2'd0, 8'd5, 1'b1, 1'b1, 4'b0000, 1'b1,
                  1'b1, 8'd5, 64'h3, 4'b0000, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 64'h0, 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b1,
                  1'b0, 8'd5, 64'h3, 4'b0000, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 8'd7, 1'b1, 1'b1, 4'b0100, 1'b1,
                  1'b1, 8'd7, 64'hFF, 4'b0000, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 8'd8, 1'b1, 1'b1, 4'b0100, 1'b1,
                  1'b1, 8'd8, 64'hFFFF_FFFF, 4'b0100, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 64'h1234_5678_9ABC_DEF0, 2'd1, 8'd9, 1'b1, 1'b1, 4'b0011, 1'b1,
                  1'b1, 8'd9, 64'hDEF0, 4'b0100, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 64'h1234_5678_9ABC_DEF0, 2'd3, 8'd10, 1'b1, 1'b0, 4'b1111, 1'b1,
                  1'b1, 8'd10, 64'h1234_5678_9ABC_DEF0, 4'b0011, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 64'h0, 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b1,
                  1'b0, 8'd10, 64'h1234_5678_9ABC_DEF0, 4'b0011, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 64'hAB, 2'd3, 8'd3, 1'b0, 1'b1, 4'b1000, 1'b0,
                  1'b0, 8'd3, 64'hAB, 4'b0011, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 64'h0, 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0,
                  1'b0, 8'd3, 64'hAB, 4'b1000, 1'b1, 1'b0};

      step();
      step();
      rst = 1'b0;
      $display("[TB] reset state");
      checkOutput("rst_we",    64'(rf_we),     64'h0);
      checkOutput("rst_addr",  64'(rf_addr),   64'h0);
      checkOutput("rst_wdata", rf_wdata,       64'h0);
      checkOutput("rst_flags", 64'(flags_q),   64'h0);
      checkOutput("rst_carry", 64'(carry_fwd), 64'h0);
      checkOutput("rst_ready", 64'(in_ready),  64'h1);

      $display("[TB] vector table");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].vld, vecs[i].res, vecs[i].size, vecs[i].dest,
                       vecs[i].wr, vecs[i].sf, vecs[i].fl);
         rf_ready = vecs[i].rdy;
         step();
         checkOutput($sformatf("v%0d_we", i),    64'(rf_we),     64'(vecs[i].e_we));
         checkOutput($sformatf("v%0d_addr", i),  64'(rf_addr),   64'(vecs[i].e_addr));
         checkOutput($sformatf("v%0d_wdata", i), rf_wdata,       vecs[i].e_data);
         checkOutput($sformatf("v%0d_flags", i), 64'(flags_q),   64'(vecs[i].e_flags));
         checkOutput($sformatf("v%0d_ready", i), 64'(in_ready),  64'(vecs[i].e_ready));
         checkOutput($sformatf("v%0d_carry", i), 64'(carry_fwd), 64'(vecs[i].e_carry));
      end

      $display("[TB] stall with three back-to-back entries");
      wc = wr_count;
      rf_ready = 1'b0;
      applyStimulus(1'b1, 64'h1, 2'd3, 8'd1, 1'b1, 1'b0, 4'b0);
      step();
      checkOutput("stall_we1",    64'(rf_we),    64'h1);
      checkOutput("stall_data1",  rf_wdata,      64'h1);
      applyStimulus(1'b1, 64'h2, 2'd3, 8'd2, 1'b1, 1'b0, 4'b0);
      step();
      checkOutput("stall_full",   64'(in_ready), 64'h0);
      checkOutput("stall_data2",  rf_wdata,      64'h1);
      applyStimulus(1'b1, 64'h3, 2'd3, 8'd3, 1'b1, 1'b0, 4'b0);
      step();
      checkOutput("stall_full3",  64'(in_ready), 64'h0);
      checkOutput("stall_data3",  rf_wdata,      64'h1);
      checkOutput("stall_addr3",  64'(rf_addr),  64'h1);
      rf_ready = 1'b1;
      step();
      checkOutput("drain_data2",  rf_wdata,      64'h2);
      checkOutput("drain_ready",  64'(in_ready), 64'h1);
      step();
      checkOutput("drain_data3",  rf_wdata,      64'h3);
      idleIn();
      step();
      checkOutput("drain_empty",  64'(rf_we),    64'h0);
      checkOutput("drain_nwr",    64'(wr_count - wc), 64'd3);
      checkOutput("drain_wr0",    wr_log[wc],     64'h1);
      checkOutput("drain_wr1",    wr_log[wc + 1], 64'h2);
      checkOutput("drain_wr2",    wr_log[wc + 2], 64'h3);

      $display("[TB] carry forwarding");
      rf_ready = 1'b0;
      applyStimulus(1'b1, 64'h10, 2'd3, 8'd11, 1'b1, 1'b1, 4'b0010);
      step();
      checkOutput("cf_a_carry",   64'(carry_fwd),  64'h1);
      checkOutput("cf_a_flagc",   64'(flags_q[1]), 64'h0);
      applyStimulus(1'b1, 64'h20, 2'd3, 8'd12, 1'b1, 1'b0, 4'b0000);
      step();
      checkOutput("cf_b_carry",   64'(carry_fwd),  64'h1);
      checkOutput("cf_b_ready",   64'(in_ready),   64'h0);
      idleIn();
      rf_ready = 1'b1;
      step();
      step();
      checkOutput("cf_flags",     64'(flags_q),    64'b0010);
      checkOutput("cf_carry",     64'(carry_fwd),  64'h1);
      checkOutput("cf_empty",     64'(rf_we),      64'h0);

      $display("[TB] flush while full");
      rf_ready = 1'b0;
      applyStimulus(1'b1, 64'h30, 2'd3, 8'd13, 1'b1, 1'b1, 4'b1111);
      step();
      applyStimulus(1'b1, 64'h31, 2'd3, 8'd14, 1'b1, 1'b1, 4'b1111);
      step();
      checkOutput("fl_full",      64'(in_ready),   64'h0);
      wc = wr_count;
      flush = 1'b1;
      applyStimulus(1'b1, 64'h32, 2'd3, 8'd15, 1'b1, 1'b1, 4'b1111);
      step();
      flush = 1'b0;
      idleIn();
      checkOutput("fl_we",        64'(rf_we),      64'h0);
      checkOutput("fl_ready",     64'(in_ready),   64'h1);
      checkOutput("fl_flags",     64'(flags_q),    64'b0010);
      rf_ready = 1'b1;
      step();
      step();
      checkOutput("fl_nowrites",  64'(wr_count - wc), 64'd0);
      checkOutput("fl_flags2",    64'(flags_q),    64'b0010);

      $display("[TB] flush with same-cycle commit");
      rf_ready = 1'b0;
      applyStimulus(1'b1, 64'h55, 2'd3, 8'd4, 1'b1, 1'b1, 4'b1001);
      step();
      wc = wr_count;
      idleIn();
      flush = 1'b1;
      rf_ready = 1'b1;
      step();
      flush = 1'b0;
      checkOutput("flc_we",       64'(rf_we),      64'h0);
      checkOutput("flc_flags",    64'(flags_q),    64'b1001);
      checkOutput("flc_nwr",      64'(wr_count - wc), 64'd1);
      checkOutput("flc_data",     wr_log[wc],      64'h55);

      $display("[TB] reset mid-stream");
      rf_ready = 1'b0;
      applyStimulus(1'b1, 64'h77, 2'd3, 8'd20, 1'b1, 1'b1, 4'b0110);
      step();
      applyStimulus(1'b1, 64'h78, 2'd3, 8'd21, 1'b1, 1'b1, 4'b0110);
      step();
      idleIn();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("mr_we",        64'(rf_we),      64'h0);
      checkOutput("mr_addr",      64'(rf_addr),    64'h0);
      checkOutput("mr_wdata",     rf_wdata,        64'h0);
      checkOutput("mr_flags",     64'(flags_q),    64'h0);
      checkOutput("mr_carry",     64'(carry_fwd),  64'h0);
      checkOutput("mr_ready",     64'(in_ready),   64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
